// File: rtl/fifo_level_monitor_pkg.sv
// Shared constants for the FIFO level monitor: threshold-select encodings
// and the default hysteresis thresholds.
package fifo_level_monitor_pkg;

  typedef enum logic [1:0] {
    CFG_FULL_HI = 2'd0,
    CFG_FULL_LO = 2'd1,
    CFG_RDY_HI  = 2'd2,
    CFG_RDY_LO  = 2'd3
  } cfg_sel_e;

  localparam int FULL_HI_DEF = 120;
  localparam int FULL_LO_DEF = 100;
  localparam int RDY_HI_DEF  = 10;
  localparam int RDY_LO_DEF  = 4;

endpackage

// File: rtl/fifo_level_monitor_hyst.sv
// Single hysteresis flag: sets above hi, clears below lo, otherwise holds.
// flag_nxt is exported so the parent can register reductions in the same cycle.
module level_hyst_flag #(
  parameter int LVL_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LVL_W-1:0] lvl,
  input  logic [LVL_W-1:0] hi,
  input  logic [LVL_W-1:0] lo,
  output logic             flag,
  output logic             flag_nxt
);

  // Set is tested first so a misprogrammed lo > hi still gives a defined flag.
  always_comb begin
    flag_nxt = flag;
    if (lvl > hi)      flag_nxt = 1'b1;
    else if (lvl < lo) flag_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flag <= 1'b0;
    else          flag <= flag_nxt;
  end

endmodule

// File: rtl/fifo_level_monitor.sv
// Multi-channel FIFO level monitor: registers occupancy, derives full/ready
// flags with programmable hysteresis, and tracks per-channel peak occupancy.
module fifo_level_monitor
  import fifo_level_monitor_pkg::*;
#(
  parameter int NUM_CH      = 4,   // 1..16
  parameter int LVL_W       = 8,
  parameter int FULL_HI_RST = FULL_HI_DEF,
  parameter int FULL_LO_RST = FULL_LO_DEF,
  parameter int RDY_HI_RST  = RDY_HI_DEF,
  parameter int RDY_LO_RST  = RDY_LO_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*LVL_W-1:0] fifo_num,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  input  logic [LVL_W-1:0]        cfg_wdata,
  input  logic                    peak_clr,
  output logic [NUM_CH-1:0]       fifo_full,
  output logic [NUM_CH-1:0]       fifo_ready,
  output logic                    any_full,
  output logic                    all_ready,
  output logic [NUM_CH*LVL_W-1:0] peak_num
);

  logic [LVL_W-1:0]  lvl_reg  [NUM_CH];
  logic [LVL_W-1:0]  peak_reg [NUM_CH];
  logic [LVL_W-1:0]  full_hi, full_lo, rdy_hi, rdy_lo;
  logic [NUM_CH-1:0] full_nxt, rdy_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_hi <= LVL_W'(FULL_HI_RST);
      full_lo <= LVL_W'(FULL_LO_RST);
      rdy_hi  <= LVL_W'(RDY_HI_RST);
      rdy_lo  <= LVL_W'(RDY_LO_RST);
    end else if (cfg_we) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_FULL_HI: full_hi <= cfg_wdata;
        CFG_FULL_LO: full_lo <= cfg_wdata;
        CFG_RDY_HI:  rdy_hi  <= cfg_wdata;
        default:     rdy_lo  <= cfg_wdata;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Clear reloads the current level so a new maximum arriving with it is kept.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lvl_reg[i]  <= '0;
        peak_reg[i] <= '0;
      end else begin
        lvl_reg[i] <= fifo_num[i*LVL_W +: LVL_W];
        if (peak_clr || (lvl_reg[i] > peak_reg[i])) peak_reg[i] <= lvl_reg[i];
      end
    end

    assign peak_num[i*LVL_W +: LVL_W] = peak_reg[i];

    level_hyst_flag #(.LVL_W(LVL_W)) u_full (
      .clk      (clk),
      .reset_n  (reset_n),
      .lvl      (lvl_reg[i]),
      .hi       (full_hi),
      .lo       (full_lo),
      .flag     (fifo_full[i]),
      .flag_nxt (full_nxt[i])
    );

    level_hyst_flag #(.LVL_W(LVL_W)) u_rdy (
      .clk      (clk),
      .reset_n  (reset_n),
      .lvl      (lvl_reg[i]),
      .hi       (rdy_hi),
      .lo       (rdy_lo),
      .flag     (fifo_ready[i]),
      .flag_nxt (rdy_nxt[i])
    );
  end

  // Reductions come from next-state flags so they line up with the flag outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_full  <= 1'b0;
      all_ready <= 1'b0;
    end else begin
      any_full  <= |full_nxt;
      all_ready <= &rdy_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_level_monitor.sv
// Bench for fifo_level_monitor: a cycle-level reference model fills an expected
// queue per driven cycle; a monitor pops and compares after every clock edge.
module tb_fifo_level_monitor;
  import fifo_level_monitor_pkg::*;

  localparam int NUM_CH = 4;
  localparam int LVL_W  = 8;
  localparam int W      = 2*NUM_CH + 2 + NUM_CH*LVL_W;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NUM_CH*LVL_W-1:0] fifo_num = '0;
  logic                    cfg_we = 1'b0;
  logic [1:0]              cfg_sel = '0;
  logic [LVL_W-1:0]        cfg_wdata = '0;
  logic                    peak_clr = 1'b0;
  logic [NUM_CH-1:0]       fifo_full, fifo_ready;
  logic                    any_full, all_ready;
  logic [NUM_CH*LVL_W-1:0] peak_num;

  fifo_level_monitor #(.NUM_CH(NUM_CH), .LVL_W(LVL_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_num   (fifo_num),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .peak_clr   (peak_clr),
    .fifo_full  (fifo_full),
    .fifo_ready (fifo_ready),
    .any_full   (any_full),
    .all_ready  (all_ready),
    .peak_num   (peak_num)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  cyc    = 0;

  // Reference model: what the block has sampled, its flags, peaks and thresholds.
  int  m_lvl  [NUM_CH];
  int  m_peak [NUM_CH];
  bit  m_full [NUM_CH];
  bit  m_rdy  [NUM_CH];
  int  th     [4];
  logic [NUM_CH*LVL_W-1:0] cur_lv = '0;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_lvl[i] = 0; m_peak[i] = 0; m_full[i] = 0; m_rdy[i] = 0;
    end
    th[0] = 120; th[1] = 100; th[2] = 10; th[3] = 4;
  endtask

  task automatic set_lvl(input int ch, input int v);
    cur_lv[ch*LVL_W +: LVL_W] = LVL_W'(v);
  endtask

  // Drive one cycle of stimulus and push the outputs expected after the next edge.
  task automatic step(input bit we = 1'b0, input int sel = 0, input int wd = 0,
                      input bit clr = 1'b0);
    logic [NUM_CH-1:0]       e_full, e_rdy;
    logic [NUM_CH*LVL_W-1:0] e_peak;
    @(negedge clk);
    fifo_num  = cur_lv;
    cfg_we    = we;
    cfg_sel   = 2'(sel);
    cfg_wdata = LVL_W'(wd);
    peak_clr  = clr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_lvl[i] > th[0])      m_full[i] = 1;
      else if (m_lvl[i] < th[1]) m_full[i] = 0;
      if (m_lvl[i] > th[2])      m_rdy[i] = 1;
      else if (m_lvl[i] < th[3]) m_rdy[i] = 0;
      if (clr || m_lvl[i] > m_peak[i]) m_peak[i] = m_lvl[i];
      e_full[i] = m_full[i];
      e_rdy[i]  = m_rdy[i];
      e_peak[i*LVL_W +: LVL_W] = LVL_W'(m_peak[i]);
      m_lvl[i] = int'(cur_lv[i*LVL_W +: LVL_W]);
    end
    if (we) th[sel] = wd;
    exp_q.push_back({e_full, e_rdy, (e_full != '0), (&e_rdy), e_peak});
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({fifo_full, fifo_ready, any_full, all_ready, peak_num} !== '0) begin
      errors++;
      $display("FAIL %s act=%h exp=0", name,
               {fifo_full, fifo_ready, any_full, all_ready, peak_num});
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL exp_q_underflow cyc=%0d act=empty exp=entry", cyc);
        end else begin
          logic [W-1:0] exp_v, act_v;
          exp_v = exp_q.pop_front();
          act_v = {fifo_full, fifo_ready, any_full, all_ready, peak_num};
          checks++;
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, act_v, exp_v);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    check_zero("reset_state");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Ramp ch0 up then down through both hysteresis bands.
    for (int v = 0; v <= 130; v++) begin set_lvl(0, v); step(); end
    for (int v = 130; v >= 0; v--) begin set_lvl(0, v); step(); end

    // ch1 toggles across the full band, then parks inside it.
    set_lvl(1, 100); repeat (5) step();
    for (int k = 0; k < 6; k++) begin
      set_lvl(1, (k % 2 == 0) ? 121 : 99);
      repeat (5) step();
    end
    set_lvl(1, 121); repeat (3) step();
    set_lvl(1, 110); repeat (10) step();

    // Lower full_hi with ch2 steady at 60.
    set_lvl(2, 60); repeat (3) step();
    step(1'b1, CFG_FULL_HI, 50);
    repeat (4) step();
    step(1'b1, CFG_FULL_HI, 120);
    repeat (2) step();

    // Peak tracking and clear on ch3.
    set_lvl(3, 30); repeat (2) step();
    set_lvl(3, 80); repeat (2) step();
    set_lvl(3, 40); repeat (2) step();
    set_lvl(3, 20); repeat (2) step();
    step(1'b0, 0, 0, 1'b1);
    repeat (2) step();
    set_lvl(3, 90); step();
    step(1'b0, 0, 0, 1'b1);
    repeat (2) step();

    // full_hi at the top code: ch0 at max level must never go full.
    step(1'b1, CFG_FULL_HI, 255);
    set_lvl(0, 255); repeat (5) step();
    set_lvl(0, 0);   repeat (2) step();

    // Randomised levels, threshold writes and peak clears.
    for (int n = 0; n < 400; n++) begin
      bit we, clr;
      for (int i = 0; i < NUM_CH; i++)
        set_lvl(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                               : $urandom_range(0, 130));
      we  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(we, $urandom_range(0, 3), $urandom_range(0, 130), clr);
    end

    // All channels at 50, then reset mid-run.
    for (int i = 0; i < NUM_CH; i++) set_lvl(i, 50);
    repeat (5) step();
    @(posedge clk);
    #3;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    fifo_num = '0; cur_lv = '0; cfg_we = 1'b0; peak_clr = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_zero("reset_hold");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Re-ramp to show thresholds are back at their defaults.
    for (int v = 0; v <= 130; v++) begin set_lvl(0, v); step(); end
    for (int v = 130; v >= 0; v--) begin set_lvl(0, v); step(); end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
